pipeline_hazard_ctrl: RTL and testbench

//  Central producer of stall/flush/forward controls for the 5-stage RV32I pipeline (F/D/E/M/W).

---
 rtl/hazard_pkg.sv | 39 +++
 rtl/md_stall_counter.sv | 28 ++
 rtl/pipeline_hazard_ctrl.sv | 147 ++++++++++++++
 tb/tb_pipeline_hazard_ctrl.sv | 279 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/hazard_pkg.sv
// Shared types and helpers for the pipeline hazard controller.
package hazard_pkg;

  typedef enum logic [1:0] {
    FWD_RF = 2'b00,
    FWD_W  = 2'b01,
    FWD_M  = 2'b10
  } forward_sel_t;

  typedef enum logic [1:0] {
    RST_FLUSH,
    IDLE,
    BUSY
  } hz_state_t;

  // Operand source for one E-stage operand; M is younger than W so it wins, x0 is never forwarded.
  function automatic forward_sel_t fwd_select(
    input logic [4:0] rsE,
    input logic [4:0] rdM,
    input logic       regWriteM,
    input logic [4:0] rdW,
    input logic       regWriteW
  );
    forward_sel_t sel;
    sel = FWD_RF;
    if (regWriteM && (rdM != 5'd0) && (rdM == rsE)) begin
      sel = FWD_M;
    end else if (regWriteW && (rdW != 5'd0) && (rdW == rsE)) begin
      sel = FWD_W;
    end
    return sel;
  endfunction

  // Counter width able to hold n-1, never narrower than one bit.
  function automatic int unsigned cnt_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/md_stall_counter.sv
// Down-counter with load and zero flag; sequences mul/div and post-reset flush windows.
module md_stall_counter #(
  parameter int unsigned          WIDTH     = 3,
  parameter logic [WIDTH-1:0]     RESET_VAL = '0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic             dec,
  input  logic [WIDTH-1:0] load_val,
  output logic [WIDTH-1:0] count,
  output logic             zero
);

  // Load has priority over decrement; decrement stops at zero.
  always_ff @(posedge clk) begin
    if (reset) begin
      count <= RESET_VAL;
    end else if (load) begin
      count <= load_val;
    end else if (dec && (count != '0)) begin
      count <= count - WIDTH'(1);
    end
  end

  assign zero = (count == '0);

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// Stall/flush/forward control for the 5-stage RV32I pipeline.
module pipeline_hazard_ctrl
  import hazard_pkg::*;
#(
  parameter int unsigned MD_LATENCY  = 8,
  parameter int unsigned RESET_FLUSH = 2,
  parameter int unsigned PERF_WIDTH  = 32
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [4:0]            rs1D,
  input  logic [4:0]            rs2D,
  input  logic                  useRs1D,
  input  logic                  useRs2D,
  input  logic [4:0]            rs1E,
  input  logic [4:0]            rs2E,
  input  logic [4:0]            rdE,
  input  logic                  regWriteE,
  input  logic                  memReadE,
  input  logic                  mdStartE,
  input  logic                  branchTakenE,
  input  logic [4:0]            rdM,
  input  logic [4:0]            rdW,
  input  logic                  regWriteM,
  input  logic                  regWriteW,
  output logic                  stallF,
  output logic                  stallD,
  output logic                  stallE,
  output logic                  flushD,
  output logic                  flushE,
  output logic                  flushM,
  output logic [1:0]            forwardAE,
  output logic [1:0]            forwardBE,
  output logic                  mdBusy,
  output logic [PERF_WIDTH-1:0] stallCount
);

  localparam int unsigned MDW = cnt_width(MD_LATENCY);
  localparam int unsigned RFW = cnt_width(RESET_FLUSH);

  hz_state_t state, state_nxt;
  logic      md_zero, rf_zero;
  logic      load_use;
  logic [MDW-1:0] md_count;
  logic [RFW-1:0] rf_count;

  assign load_use = memReadE && regWriteE && (rdE != 5'd0) &&
                    ((useRs1D && (rs1D == rdE)) || (useRs2D && (rs2D == rdE)));

  // Mul/div occupancy: loaded when the op first reaches E, runs down while BUSY.
  md_stall_counter #(
    .WIDTH     (MDW),
    .RESET_VAL ('0)
  ) u_md_cnt (
    .clk      (clk),
    .reset    (reset),
    .load     ((state == IDLE) && mdStartE),
    .dec      (state == BUSY),
    .load_val (MDW'(MD_LATENCY - 2)),
    .count    (md_count),
    .zero     (md_zero)
  );

  // Post-reset flush window: preset by reset itself, runs down in RST_FLUSH.
  md_stall_counter #(
    .WIDTH     (RFW),
    .RESET_VAL (RFW'(RESET_FLUSH - 1))
  ) u_rf_cnt (
    .clk      (clk),
    .reset    (reset),
    .load     (1'b0),
    .dec      (state == RST_FLUSH),
    .load_val ('0),
    .count    (rf_count),
    .zero     (rf_zero)
  );

  // State register; reset always re-enters the flush window and abandons any mul/div.
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= RST_FLUSH;
    end else begin
      state <= state_nxt;
    end
  end

  // Next state and stall/flush controls, priority RST_FLUSH > mul/div > branch > load-use.
  always_comb begin
    state_nxt = state;
    stallF    = 1'b0;
    stallD    = 1'b0;
    stallE    = 1'b0;
    flushD    = 1'b0;
    flushE    = 1'b0;
    flushM    = 1'b0;
    case (state)
      RST_FLUSH: begin
        stallF = 1'b1;
        flushD = 1'b1;
        flushE = 1'b1;
        flushM = 1'b1;
        if (rf_zero) state_nxt = IDLE;
      end
      BUSY: begin
        if (md_zero) begin
          state_nxt = IDLE;
        end else begin
          stallF = 1'b1;
          stallD = 1'b1;
          stallE = 1'b1;
          flushM = 1'b1;
        end
      end
      IDLE: begin
        if (mdStartE) begin
          stallF    = 1'b1;
          stallD    = 1'b1;
          stallE    = 1'b1;
          flushM    = 1'b1;
          state_nxt = BUSY;
        end else if (branchTakenE) begin
          flushD = 1'b1;
          flushE = 1'b1;
        end else if (load_use) begin
          stallF = 1'b1;
          stallD = 1'b1;
          flushE = 1'b1;
        end
      end
      default: state_nxt = RST_FLUSH;
    endcase
  end

  assign mdBusy    = (state == BUSY);
  assign forwardAE = fwd_select(rs1E, rdM, regWriteM, rdW, regWriteW);
  assign forwardBE = fwd_select(rs2E, rdM, regWriteM, rdW, regWriteW);

  // Saturating count of fetch-stall cycles.
  always_ff @(posedge clk) begin
    if (reset) begin
      stallCount <= '0;
    end else if (stallF && (stallCount != '1)) begin
      stallCount <= stallCount + PERF_WIDTH'(1);
    end
  end

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Self-checking bench for pipeline_hazard_ctrl: vector table, hand sequences, random vs. reference model.
module tb_pipeline_hazard_ctrl;

  localparam int unsigned MDL     = 8;
  localparam int unsigned RFL     = 2;
  localparam int unsigned PW      = 6;
  localparam int unsigned CNT_MAX = (1 << PW) - 1;

  logic          clk, reset;
  logic [4:0]    rs1D, rs2D, rs1E, rs2E, rdE, rdM, rdW;
  logic          useRs1D, useRs2D, regWriteE, memReadE, mdStartE, branchTakenE;
  logic          regWriteM, regWriteW;
  logic          stallF, stallD, stallE, flushD, flushE, flushM, mdBusy;
  logic [1:0]    forwardAE, forwardBE;
  logic [PW-1:0] stallCount;

  pipeline_hazard_ctrl #(
    .MD_LATENCY  (MDL),
    .RESET_FLUSH (RFL),
    .PERF_WIDTH  (PW)
  ) dut (
    .clk(clk), .reset(reset),
    .rs1D(rs1D), .rs2D(rs2D), .useRs1D(useRs1D), .useRs2D(useRs2D),
    .rs1E(rs1E), .rs2E(rs2E), .rdE(rdE), .regWriteE(regWriteE), .memReadE(memReadE),
    .mdStartE(mdStartE), .branchTakenE(branchTakenE),
    .rdM(rdM), .rdW(rdW), .regWriteM(regWriteM), .regWriteW(regWriteW),
    .stallF(stallF), .stallD(stallD), .stallE(stallE),
    .flushD(flushD), .flushE(flushE), .flushM(flushM),
    .forwardAE(forwardAE), .forwardBE(forwardBE),
    .mdBusy(mdBusy), .stallCount(stallCount)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // One instruction in E cannot be both a mul/div start and a taken branch.
  always @(posedge clk) begin
    if (!reset) assert (!(mdStartE && branchTakenE)) else $error("mdStartE with branchTakenE");
  end

  int unsigned tests = 0;
  int unsigned fails = 0;

  // Reference model: remaining flush cycles, remaining mul/div occupancy cycles, stall count.
  int          rf_left = 0;
  int          md_occ  = 0;
  int unsigned cnt_ref = 0;

  task automatic chk(input string name, input int unsigned act, input int unsigned exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  function automatic logic [1:0] fwd_ref(input logic [4:0] rs);
    if (regWriteM && rdM != 0 && rdM == rs) return 2'b10;
    if (regWriteW && rdW != 0 && rdW == rs) return 2'b01;
    return 2'b00;
  endfunction

  // Compare all outputs to the model for the current cycle, then advance the model across the edge.
  task automatic cyc(input string tag);
    logic sF, sD, sE, fD, fE, fM, busy, lu;
    logic [10:0] e, a;
    sF = 0; sD = 0; sE = 0; fD = 0; fE = 0; fM = 0;
    lu = memReadE && regWriteE && rdE != 0 &&
         ((useRs1D && rs1D == rdE) || (useRs2D && rs2D == rdE));
    busy = (rf_left == 0) && (md_occ > 0);
    if (rf_left > 0) begin
      sF = 1; fD = 1; fE = 1; fM = 1;
    end else if (md_occ > 0) begin
      if (md_occ > 1) begin sF = 1; sD = 1; sE = 1; fM = 1; end
    end else if (mdStartE) begin
      sF = 1; sD = 1; sE = 1; fM = 1;
    end else if (branchTakenE) begin
      fD = 1; fE = 1;
    end else if (lu) begin
      sF = 1; sD = 1; fE = 1;
    end
    e = {sF, sD, sE, fD, fE, fM, fwd_ref(rs1E), fwd_ref(rs2E), busy};
    a = {stallF, stallD, stallE, flushD, flushE, flushM, forwardAE, forwardBE, mdBusy};
    tests++;
    if (a !== e) begin
      fails++;
      $display("FAIL %s.ctl: got %b expected %b (sF sD sE fD fE fM fa fb busy)", tag, a, e);
    end
    chk({tag, ".stallCount"}, int'(stallCount), cnt_ref);
    if (reset) begin
      rf_left = RFL; md_occ = 0; cnt_ref = 0;
    end else begin
      if (sF && cnt_ref < CNT_MAX) cnt_ref++;
      if (rf_left > 0)      rf_left--;
      else if (md_occ > 0)  md_occ--;
      else if (mdStartE)    md_occ = MDL - 1;
    end
    @(negedge clk);
  endtask

  task automatic tick(input string tag);
    #1;
    cyc(tag);
  endtask

  task automatic set_idle();
    rs1D = 0; rs2D = 0; useRs1D = 0; useRs2D = 0; rs1E = 0; rs2E = 0; rdE = 0;
    regWriteE = 0; memReadE = 0; mdStartE = 0; branchTakenE = 0;
    rdM = 0; rdW = 0; regWriteM = 0; regWriteW = 0;
  endtask

  typedef struct {
    logic [4:0] rs1D, rs2D;
    logic       u1, u2;
    logic [4:0] rs1E, rs2E, rdE;
    logic       wE, mrE, br;
    logic [4:0] rdM, rdW;
    logic       wM, wW;
    logic       sF, sD, fD, fE;
    logic [1:0] fa, fb;
  } vec_t;

  function automatic vec_t mkv(input int unsigned a_rs1D, a_rs2D, a_u1, a_u2, a_rs1E, a_rs2E,
                               a_rdE, a_wE, a_mrE, a_br, a_rdM, a_rdW, a_wM, a_wW,
                               e_sF, e_sD, e_fD, e_fE, e_fa, e_fb);
    vec_t v;
    v.rs1D = 5'(a_rs1D); v.rs2D = 5'(a_rs2D); v.u1 = 1'(a_u1); v.u2 = 1'(a_u2);
    v.rs1E = 5'(a_rs1E); v.rs2E = 5'(a_rs2E); v.rdE = 5'(a_rdE);
    v.wE = 1'(a_wE); v.mrE = 1'(a_mrE); v.br = 1'(a_br);
    v.rdM = 5'(a_rdM); v.rdW = 5'(a_rdW); v.wM = 1'(a_wM); v.wW = 1'(a_wW);
    v.sF = 1'(e_sF); v.sD = 1'(e_sD); v.fD = 1'(e_fD); v.fE = 1'(e_fE);
    v.fa = 2'(e_fa); v.fb = 2'(e_fb);
    return v;
  endfunction

  vec_t vecs[9];

  initial begin
    int unsigned nstall, nbusy;

    vecs[0] = mkv(5,0,1,0, 7,3, 5,1,1,0, 7,7,1,1, 1,1,0,1, 2,0);  // load-use on rs1, fwd M
    vecs[1] = mkv(0,0,1,1, 7,3, 0,1,1,0, 7,7,0,1, 0,0,0,0, 1,0);  // rdE=x0: no stall, fwd W
    vecs[2] = mkv(5,0,1,0, 0,0, 5,1,1,1, 0,0,1,1, 0,0,1,1, 0,0);  // branch suppresses load-use
    vecs[3] = mkv(1,5,0,1, 4,7, 5,1,1,0, 4,7,1,1, 1,1,0,1, 2,1);  // load-use on rs2
    vecs[4] = mkv(5,6,0,0, 7,7, 5,1,1,0, 7,7,1,0, 0,0,0,0, 2,2);  // match but rs1 not used
    vecs[5] = mkv(5,0,1,0, 5,5, 5,1,0,0, 5,5,0,0, 0,0,0,0, 0,0);  // ALU producer: no stall
    vecs[6] = mkv(5,0,1,0, 9,2, 5,0,1,0, 9,2,0,1, 0,0,0,0, 0,1);  // load w/o regWrite
    vecs[7] = mkv(3,3,1,1, 0,0, 0,0,0,1, 0,0,0,0, 0,0,1,1, 0,0);  // plain taken branch
    vecs[8] = mkv(3,3,1,1, 3,3, 3,1,1,0, 3,3,1,1, 1,1,0,1, 2,2);  // both sources hit

    set_idle();
    reset = 1;
    @(negedge clk);
    @(negedge clk);
    rf_left = RFL; md_occ = 0; cnt_ref = 0;

    // Reset held: flush window, counters cleared.
    #1;
    chk("rst.flushD", int'(flushD), 1);
    chk("rst.mdBusy", int'(mdBusy), 0);
    chk("rst.stallCount", int'(stallCount), 0);
    cyc("rst");
    reset = 0;
    for (int unsigned i = 0; i < RFL; i++) begin
      #1;
      chk("rflush.flushD", int'(flushD), 1);
      chk("rflush.flushE", int'(flushE), 1);
      chk("rflush.flushM", int'(flushM), 1);
      chk("rflush.stallF", int'(stallF), 1);
      cyc("rflush");
    end
    #1;
    chk("post_rst.flushD", int'(flushD), 0);
    chk("post_rst.stallF", int'(stallF), 0);
    chk("post_rst.stallCount", int'(stallCount), 2);
    cyc("post_rst");

    // Vector table in IDLE.
    for (int unsigned i = 0; i < 9; i++) begin
      rs1D = vecs[i].rs1D; rs2D = vecs[i].rs2D; useRs1D = vecs[i].u1; useRs2D = vecs[i].u2;
      rs1E = vecs[i].rs1E; rs2E = vecs[i].rs2E; rdE = vecs[i].rdE;
      regWriteE = vecs[i].wE; memReadE = vecs[i].mrE; branchTakenE = vecs[i].br;
      rdM = vecs[i].rdM; rdW = vecs[i].rdW; regWriteM = vecs[i].wM; regWriteW = vecs[i].wW;
      mdStartE = 0;
      #1;
      chk($sformatf("vec%0d.stallF", i), int'(stallF), int'(vecs[i].sF));
      chk($sformatf("vec%0d.stallD", i), int'(stallD), int'(vecs[i].sD));
      chk($sformatf("vec%0d.stallE", i), int'(stallE), 0);
      chk($sformatf("vec%0d.flushD", i), int'(flushD), int'(vecs[i].fD));
      chk($sformatf("vec%0d.flushE", i), int'(flushE), int'(vecs[i].fE));
      chk($sformatf("vec%0d.flushM", i), int'(flushM), 0);
      chk($sformatf("vec%0d.forwardAE", i), int'(forwardAE), int'(vecs[i].fa));
      chk($sformatf("vec%0d.forwardBE", i), int'(forwardBE), int'(vecs[i].fb));
      cyc($sformatf("vec%0d", i));
    end

    // Mul/div: 7 stall cycles, 7 busy cycles; branch and load-use ignored while busy.
    set_idle();
    mdStartE = 1;
    nstall = 0; nbusy = 0;
    #1;
    chk("md.start.stallE", int'(stallE), 1);
    chk("md.start.flushM", int'(flushM), 1);
    if (stallF) nstall++;
    if (mdBusy) nbusy++;
    cyc("md.start");
    mdStartE = 0;
    for (int unsigned i = 0; i < MDL - 1; i++) begin
      set_idle();
      if (i == 2) branchTakenE = 1;
      if (i == 3) begin memReadE = 1; regWriteE = 1; rdE = 5; rs1D = 5; useRs1D = 1; end
      #1;
      chk($sformatf("md.busy%0d.flushD", i), int'(flushD), 0);
      if (stallF) nstall++;
      if (mdBusy) nbusy++;
      cyc($sformatf("md.busy%0d", i));
    end
    set_idle();
    #1;
    chk("md.done.mdBusy", int'(mdBusy), 0);
    chk("md.done.stallF", int'(stallF), 0);
    chk("md.stall_cycles", nstall, MDL - 1);
    chk("md.busy_cycles", nbusy, MDL - 1);
    cyc("md.done");

    // Reset during BUSY cycle 3 abandons the op.
    mdStartE = 1;
    tick("mdr.start");
    mdStartE = 0;
    tick("mdr.b1");
    tick("mdr.b2");
    reset = 1;
    tick("mdr.b3");
    reset = 0;
    #1;
    chk("mdr.after.mdBusy", int'(mdBusy), 0);
    chk("mdr.after.flushM", int'(flushM), 1);
    cyc("mdr.after");
    tick("mdr.rf2");

    // Drive the stall counter into saturation with back-to-back mul/div ops.
    for (int unsigned k = 0; k < 10; k++) begin
      mdStartE = 1;
      tick("sat.start");
      mdStartE = 0;
      for (int unsigned j = 0; j < MDL - 1; j++) tick("sat.busy");
    end
    #1;
    chk("sat.stallCount", int'(stallCount), CNT_MAX);
    cyc("sat.hold");

    // Random traffic against the reference model.
    for (int unsigned n = 0; n < 1500; n++) begin
      rs1D = 5'($urandom_range(0, 3)); rs2D = 5'($urandom_range(0, 3));
      rs1E = 5'($urandom_range(0, 3)); rs2E = 5'($urandom_range(0, 3));
      rdE  = 5'($urandom_range(0, 3)); rdM  = 5'($urandom_range(0, 3));
      rdW  = 5'($urandom_range(0, 3));
      useRs1D = 1'($urandom); useRs2D = 1'($urandom);
      regWriteE = ($urandom_range(0, 3) != 0); memReadE = 1'($urandom);
      regWriteM = 1'($urandom); regWriteW = 1'($urandom);
      mdStartE = ($urandom_range(0, 15) == 0);
      branchTakenE = mdStartE ? 1'b0 : ($urandom_range(0, 5) == 0);
      reset = ($urandom_range(0, 99) == 0);
      tick("rand");
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
